can_tx_frame_tail: RTL and testbench

Transmit-side counterpart of the receive EOF checker: serializes the tail of a CAN data/remote frame from the CRC sequence to the end of intermission. Drives the 15-bit CRC with bit stuffing, then CRC delimiter, ACK slot, ACK delimiter, 7 EOF bits and 3 intermission bits. Monitors the bus at each sample point for acknowledge and for bit and form errors. Sits between the TX frame sequencer, which hands over at the end of the data field, and the CAN TX pin.

---
 rtl/can_tx_frame_tail.sv | 188 ++++++++++++++++++
 tb/tb_can_tx_frame_tail.sv | 262 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/can_tx_frame_tail.sv
// can_tx_frame_tail
// Serializes the tail of a CAN data/remote frame: stuffed 15-bit CRC, CRC
// delimiter, ACK slot, ACK delimiter, 7 EOF bits and 3 intermission bits.
// The bus is checked at every sample point for acknowledge, bit errors,
// form errors and overload conditions in intermission.
module can_tx_frame_tail (
    input  logic        clk,
    input  logic        reset,
    input  logic        tx_pt,
    input  logic        sp,
    input  logic        rx,
    input  logic        start,
    input  logic [14:0] crc,
    input  logic        stuff_lvl,
    input  logic [2:0]  stuff_cnt,
    output logic        tx,
    output logic        busy,
    output logic        ack_ok,
    output logic        ack_err,
    output logic        bit_err,
    output logic        form_err,
    output logic        ovl,
    output logic        done
);

    typedef enum logic [2:0] {
        IDLE,
        CRC,
        CRC_DELIM,
        ACK_SLOT,
        ACK_DELIM,
        EOF,
        IFS
    } state_t;

    state_t      state;
    state_t      state_next;

    logic [14:0] crc_sr;
    logic        run_lvl;
    logic [2:0]  run_cnt;
    logic [3:0]  bit_cnt;

    logic        accept;
    logic        stuff_now;
    logic        emit;
    logic        ack_ok_now;
    logic        ack_err_now;
    logic        bit_err_now;
    logic        form_err_now;
    logic        ovl_now;
    logic        end_now;
    logic        abort_now;

    // State register; reset parks the machine in IDLE
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next state: sample-point events (abort/completion) win over bit-time advances
    always_comb begin
        state_next = state;
        if (abort_now || end_now) begin
            state_next = IDLE;
        end else if (tx_pt) begin
            case (state)
                IDLE:      if (busy) state_next = CRC;
                CRC:       if (bit_cnt == 4'd15 && !stuff_now) state_next = CRC_DELIM;
                CRC_DELIM: state_next = ACK_SLOT;
                ACK_SLOT:  state_next = ACK_DELIM;
                ACK_DELIM: state_next = EOF;
                EOF:       if (bit_cnt == 4'd6) state_next = IFS;
                IFS:       state_next = IFS;
                default:   state_next = IDLE;
            endcase
        end
    end

    // Decode of bus checks at the sample point and of what the next bit time drives
    always_comb begin
        ack_ok_now   = 1'b0;
        ack_err_now  = 1'b0;
        bit_err_now  = 1'b0;
        form_err_now = 1'b0;
        ovl_now      = 1'b0;
        end_now      = 1'b0;
        if (sp) begin
            case (state)
                CRC:       bit_err_now = (rx != tx);
                CRC_DELIM,
                ACK_DELIM,
                EOF:       form_err_now = !rx;
                ACK_SLOT: begin
                    ack_ok_now  = !rx;
                    ack_err_now = rx;
                end
                IFS: begin
                    if (bit_cnt == 4'd2) begin
                        end_now = 1'b1;
                    end else begin
                        ovl_now = !rx;
                    end
                end
                default: ;
            endcase
        end
        abort_now = bit_err_now || form_err_now || ack_err_now;
        accept    = start && !busy;
        stuff_now = (run_cnt == 3'd5);
        emit      = tx_pt && !abort_now && !end_now &&
                    ((state == IDLE && busy) ||
                     (state == CRC && (bit_cnt != 4'd15 || stuff_now)));
    end

    // CRC shifter, stuffing run tracker and per-field bit counter
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            crc_sr  <= 15'd0;
            run_lvl <= 1'b0;
            run_cnt <= 3'd0;
            bit_cnt <= 4'd0;
        end else if (accept) begin
            crc_sr  <= crc;
            run_lvl <= stuff_lvl;
            run_cnt <= stuff_cnt;
            bit_cnt <= 4'd0;
        end else if (emit) begin
            if (stuff_now) begin
                run_lvl <= ~run_lvl;
                run_cnt <= 3'd1;
            end else begin
                crc_sr  <= {crc_sr[13:0], 1'b0};
                bit_cnt <= bit_cnt + 4'd1;
                if (crc_sr[14] == run_lvl) begin
                    run_cnt <= run_cnt + 3'd1;
                end else begin
                    run_lvl <= crc_sr[14];
                    run_cnt <= 3'd1;
                end
            end
        end else if (tx_pt && !abort_now && !end_now) begin
            if (state_next != state) begin
                bit_cnt <= 4'd0;
            end else if (state == EOF || (state == IFS && bit_cnt != 4'd2)) begin
                bit_cnt <= bit_cnt + 4'd1;
            end
        end
    end

    // Registered bus drive, busy flag and one-cycle status pulses
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            tx       <= 1'b1;
            busy     <= 1'b0;
            ack_ok   <= 1'b0;
            ack_err  <= 1'b0;
            bit_err  <= 1'b0;
            form_err <= 1'b0;
            ovl      <= 1'b0;
            done     <= 1'b0;
        end else begin
            ack_ok   <= ack_ok_now;
            ack_err  <= ack_err_now;
            bit_err  <= bit_err_now;
            form_err <= form_err_now;
            ovl      <= ovl_now;
            done     <= end_now;
            if (abort_now || end_now) begin
                tx   <= 1'b1;
                busy <= 1'b0;
            end else begin
                if (accept) begin
                    busy <= 1'b1;
                end
                if (emit) begin
                    tx <= stuff_now ? ~run_lvl : crc_sr[14];
                end else if (tx_pt) begin
                    tx <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_can_tx_frame_tail.sv
// tb_can_tx_frame_tail
// Scoreboard bench: each frame tail is planned bit by bit from a reference
// stuffing model, pushed to a queue, then popped one bit time at a time while
// the bench plays the bus and compares tx and the status pulses.
module tb_can_tx_frame_tail;

    localparam int F_NONE  = 0;
    localparam int F_BIT   = 1;
    localparam int F_FORM  = 2;
    localparam int F_OVL   = 3;
    localparam int F_RESET = 4;

    // One planned bit time: what tx must be, what the bus shows at sp, and
    // which pulse vector {ack_ok,ack_err,bit_err,form_err,ovl,done} follows
    typedef struct packed {
        logic       exp_tx;
        logic       drive_rx;
        logic [5:0] exp_pulse;
        logic       last;
        logic       reset_here;
    } bit_t;

    logic        clk;
    logic        reset;
    logic        tx_pt;
    logic        sp;
    logic        rx;
    logic        start;
    logic [14:0] crc_in;
    logic        stuff_lvl;
    logic [2:0]  stuff_cnt;
    logic        tx;
    logic        busy;
    logic        ack_ok;
    logic        ack_err;
    logic        bit_err;
    logic        form_err;
    logic        ovl;
    logic        done;
    logic [5:0]  pulses;

    bit_t sb[$];
    int   vec_count;
    int   miss_count;

    assign pulses = {ack_ok, ack_err, bit_err, form_err, ovl, done};

    can_tx_frame_tail dut (
        .clk       (clk),
        .reset     (reset),
        .tx_pt     (tx_pt),
        .sp        (sp),
        .rx        (rx),
        .start     (start),
        .crc       (crc_in),
        .stuff_lvl (stuff_lvl),
        .stuff_cnt (stuff_cnt),
        .tx        (tx),
        .busy      (busy),
        .ack_ok    (ack_ok),
        .ack_err   (ack_err),
        .bit_err   (bit_err),
        .form_err  (form_err),
        .ovl       (ovl),
        .done      (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Single comparison point: counts every vector and reports mismatches
    task automatic checkOutput(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        vec_count++;
        if (obs !== exp) begin
            miss_count++;
            $display("[TB] FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // Build the expected bit-time plan for one tail; stuffing is derived from
    // a five-bit history window of everything already on the bus
    task automatic buildFrame(input logic [14:0] c, input logic lvl, input logic [2:0] cnt,
                              input logic ack_dom, input int fkind, input int fpos);
        logic [4:0] h;
        int         hn;
        logic       f[$];
        logic       b;
        bit_t       e;
        h  = 5'd0;
        hn = 0;
        if (cnt < 3'd5) begin
            h = {h[3:0], ~lvl};
            hn++;
        end
        for (int i = 0; i < int'(cnt); i++) begin
            h = {h[3:0], lvl};
            hn++;
        end
        for (int i = 14; i >= 0; i--) begin
            if (hn >= 5 && (h == 5'b00000 || h == 5'b11111)) begin
                b = ~h[0];
                f.push_back(b);
                h = {h[3:0], b};
                hn++;
            end
            b = c[i];
            f.push_back(b);
            h = {h[3:0], b};
            hn++;
        end
        if (h == 5'b00000 || h == 5'b11111) begin
            f.push_back(~h[0]);
        end
        // CRC field, optionally corrupted at the first dominant bit from fpos on
        for (int k = 0; k < f.size(); k++) begin
            e = '{exp_tx: f[k], drive_rx: f[k], exp_pulse: 6'b000000, last: 1'b0, reset_here: 1'b0};
            if (fkind == F_BIT && k >= fpos && f[k] == 1'b0) begin
                e.drive_rx  = 1'b1;
                e.exp_pulse = 6'b001000;
                e.last      = 1'b1;
                sb.push_back(e);
                return;
            end
            sb.push_back(e);
        end
        sb.push_back('{exp_tx: 1'b1, drive_rx: 1'b1, exp_pulse: 6'b000000, last: 1'b0, reset_here: 1'b0});
        e = '{exp_tx: 1'b1, drive_rx: ~ack_dom, exp_pulse: (ack_dom ? 6'b100000 : 6'b010000),
              last: ~ack_dom, reset_here: 1'b0};
        sb.push_back(e);
        if (!ack_dom) return;
        sb.push_back('{exp_tx: 1'b1, drive_rx: 1'b1, exp_pulse: 6'b000000, last: 1'b0, reset_here: 1'b0});
        for (int i = 1; i <= 7; i++) begin
            e = '{exp_tx: 1'b1, drive_rx: 1'b1, exp_pulse: 6'b000000, last: 1'b0,
                  reset_here: (fkind == F_RESET && i == fpos)};
            if (fkind == F_FORM && i == fpos) begin
                e.drive_rx  = 1'b0;
                e.exp_pulse = 6'b000100;
                e.last      = 1'b1;
                sb.push_back(e);
                return;
            end
            sb.push_back(e);
        end
        for (int i = 1; i <= 3; i++) begin
            e = '{exp_tx: 1'b1, drive_rx: 1'b1, exp_pulse: 6'b000000, last: (i == 3), reset_here: 1'b0};
            if (fkind == F_OVL && i == fpos) e.drive_rx = 1'b0;
            if (i == 3) e.exp_pulse = 6'b000001;
            else if (fkind == F_OVL && i == fpos) e.exp_pulse = 6'b000010;
            sb.push_back(e);
        end
    endtask

    // Issue one start, then play the planned bit times: tx_pt, gap, sp, gap
    task automatic applyStimulus(input logic [14:0] c, input logic lvl, input logic [2:0] cnt,
                                 input logic ack_dom, input int fkind, input int fpos,
                                 input logic start_mid);
        bit_t e;
        int   n;
        sb.delete();
        buildFrame(c, lvl, cnt, ack_dom, fkind, fpos);
        crc_in    = c;
        stuff_lvl = lvl;
        stuff_cnt = cnt;
        start     = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        checkOutput("busy_after_start", busy, 1);
        checkOutput("tx_before_first_pt", tx, 1);
        @(posedge clk); #1;
        n = 0;
        while (sb.size() > 0) begin
            e = sb.pop_front();
            tx_pt = 1'b1;
            @(posedge clk); #1;
            tx_pt = 1'b0;
            checkOutput("tx_bit", tx, e.exp_tx);
            checkOutput("busy_in_frame", busy, 1);
            if (e.reset_here) begin
                reset = 1'b1;
                #1;
                checkOutput("reset_mid_tx", tx, 1);
                checkOutput("reset_mid_busy", busy, 0);
                @(posedge clk); #1;
                reset = 1'b0;
                checkOutput("reset_mid_pulses", pulses, 0);
                sb.delete();
                break;
            end
            if (start_mid && n == 3) begin
                crc_in    = ~c;
                stuff_lvl = ~lvl;
                stuff_cnt = 3'd2;
                start     = 1'b1;
            end
            @(posedge clk); #1;
            start = 1'b0;
            sp    = 1'b1;
            rx    = e.drive_rx;
            @(posedge clk); #1;
            sp = 1'b0;
            rx = 1'b1;
            checkOutput("pulses", pulses, e.exp_pulse);
            @(posedge clk); #1;
            if (e.last) begin
                checkOutput("end_busy", busy, 0);
                checkOutput("end_tx", tx, 1);
                checkOutput("pulse_width", pulses, 0);
            end
            n++;
        end
        repeat (2) @(posedge clk);
        #1;
    endtask

    initial begin
        vec_count  = 0;
        miss_count = 0;
        reset      = 1'b1;
        tx_pt      = 1'b0;
        sp         = 1'b0;
        rx         = 1'b1;
        start      = 1'b0;
        crc_in     = 15'd0;
        stuff_lvl  = 1'b0;
        stuff_cnt  = 3'd0;
        repeat (2) @(posedge clk);
        #1;
        checkOutput("reset_tx", tx, 1);
        checkOutput("reset_busy", busy, 0);
        checkOutput("reset_pulses", pulses, 0);
        reset = 1'b0;
        @(posedge clk); #1;

        // All-zero CRC: three stuff bits, ACK seen, done
        applyStimulus(15'h0000, 1'b1, 3'd1, 1'b1, F_NONE, 0, 1'b0);
        // Seeded run: stuff right after the first CRC bit
        applyStimulus(15'h7C00, 1'b1, 3'd4, 1'b1, F_NONE, 0, 1'b0);
        // Stuff bit after crc[0], before the delimiter
        applyStimulus(15'h001F, 1'b0, 3'd1, 1'b1, F_NONE, 0, 1'b0);
        // Recessive ACK slot
        applyStimulus(15'h1234, 1'b0, 3'd2, 1'b0, F_NONE, 0, 1'b0);
        // Dominant at EOF bit 4
        applyStimulus(15'h5A5A, 1'b1, 3'd3, 1'b1, F_FORM, 4, 1'b0);
        // Recessive read back while driving dominant in CRC
        applyStimulus(15'h0F0F, 1'b0, 3'd1, 1'b1, F_BIT, 3, 1'b0);
        // Overload at IFS bit 2, with a start request while busy
        applyStimulus(15'h2AAA, 1'b1, 3'd2, 1'b1, F_OVL, 2, 1'b1);
        // Dominant at IFS bit 3 is ignored
        applyStimulus(15'h4321, 1'b0, 3'd3, 1'b1, F_OVL, 3, 1'b0);
        // Reset during EOF bit 3
        applyStimulus(15'h3C3C, 1'b0, 3'd2, 1'b1, F_RESET, 3, 1'b0);
        // A few random tails
        for (int r = 0; r < 4; r++) begin
            applyStimulus(15'($urandom), 1'($urandom_range(0, 1)), 3'($urandom_range(1, 4)),
                          1'b1, F_NONE, 0, 1'b0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vec_count, miss_count);
        $finish;
    end

endmodule
